// File: rtl/coh_snoop_hub.sv
// Coherence snoop hub: broadcasts each initiator request to NPORT peers, merges their MESI and returns one grant.
// Latency: request at t -> snoop at t+1 -> grant one cycle after the last peer answers (min 3). One pending slot; overflow drops and sets err.
module coh_snoop_hub #(
   parameter int NPORT = 2,
   parameter int TMO   = 1023
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_coh_lock,
   input  logic [7:0]           i_coh_rqst,
   input  logic [7:0]           i_coh_trsc,
   input  logic [63:0]          i_coh_addr,
   output logic [7:0]           i_coh_resp,
   output logic [7:0]           i_coh_mesi,
   output logic                 i_coh_plock,
   output logic [8*NPORT-1:0]   p_coh_rqst,
   output logic [7:0]           p_coh_trsc,
   output logic [63:0]          p_coh_addr,
   output logic                 p_coh_lock,
   input  logic [8*NPORT-1:0]   p_coh_resp,
   input  logic [8*NPORT-1:0]   p_coh_mesi,
   output logic                 err
);

   localparam int CW = (TMO > 1) ? $clog2(TMO + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SNOOP, S_WAIT, S_GRANT} state_t;

   state_t            state, state_nxt;
   logic [7:0]        cur_id, cur_id_nxt;
   logic [7:0]        cur_trsc, cur_trsc_nxt;
   logic [63:0]       cur_addr, cur_addr_nxt;
   logic              pnd_vld, pnd_vld_nxt;
   logic [7:0]        pnd_id, pnd_id_nxt;
   logic [7:0]        pnd_trsc, pnd_trsc_nxt;
   logic [63:0]       pnd_addr, pnd_addr_nxt;
   logic [NPORT-1:0]  done, done_nxt;
   logic [NPORT-1:0]  hit;
   logic [7:0]        hit_mesi;
   logic [7:0]        mesi, mesi_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic              err_q, err_nxt;
   logic              new_req;

   assign new_req = |i_coh_rqst;

   // A peer counts as done only when it echoes the id of the request in flight.
   always_comb begin
      hit      = '0;
      hit_mesi = 8'd0;
      for (int k = 0; k < NPORT; k++) begin
         hit[k] = (p_coh_resp[8*k +: 8] == cur_id);
         if (hit[k]) hit_mesi = hit_mesi | p_coh_mesi[8*k +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cur_id   <= 8'd0;
         cur_trsc <= 8'd0;
         cur_addr <= 64'd0;
         pnd_vld  <= 1'b0;
         pnd_id   <= 8'd0;
         pnd_trsc <= 8'd0;
         pnd_addr <= 64'd0;
         done     <= '0;
         mesi     <= 8'd0;
         cnt      <= '0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         cur_id   <= cur_id_nxt;
         cur_trsc <= cur_trsc_nxt;
         cur_addr <= cur_addr_nxt;
         pnd_vld  <= pnd_vld_nxt;
         pnd_id   <= pnd_id_nxt;
         pnd_trsc <= pnd_trsc_nxt;
         pnd_addr <= pnd_addr_nxt;
         done     <= done_nxt;
         mesi     <= mesi_nxt;
         cnt      <= cnt_nxt;
         err_q    <= err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cur_id_nxt   = cur_id;
      cur_trsc_nxt = cur_trsc;
      cur_addr_nxt = cur_addr;
      pnd_vld_nxt  = pnd_vld;
      pnd_id_nxt   = pnd_id;
      pnd_trsc_nxt = pnd_trsc;
      pnd_addr_nxt = pnd_addr;
      done_nxt     = done;
      mesi_nxt     = mesi;
      cnt_nxt      = cnt;
      err_nxt      = err_q;

      case (state)
         S_IDLE: begin
            if (pnd_vld) begin
               cur_id_nxt   = pnd_id;
               cur_trsc_nxt = pnd_trsc;
               cur_addr_nxt = pnd_addr;
               pnd_vld_nxt  = 1'b0;
               state_nxt    = S_SNOOP;
            end else if (new_req) begin
               cur_id_nxt   = i_coh_rqst;
               cur_trsc_nxt = i_coh_trsc;
               cur_addr_nxt = i_coh_addr;
               state_nxt    = S_SNOOP;
            end
         end
         S_SNOOP: begin
            done_nxt  = '0;
            mesi_nxt  = 8'd0;
            cnt_nxt   = '0;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            done_nxt = done | hit;
            mesi_nxt = mesi | hit_mesi;
            cnt_nxt  = cnt + CW'(1);
            if (&done_nxt) begin
               state_nxt = S_GRANT;
            end else if ((TMO != 0) && (cnt_nxt == CW'(TMO))) begin
               err_nxt   = 1'b1;
               state_nxt = S_GRANT;
            end
         end
         S_GRANT: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase

      // A request not taken directly by an idle FSM goes to the slot; in IDLE the slot is drained this cycle.
      if (new_req && !(state == S_IDLE && !pnd_vld)) begin
         if (state != S_IDLE && pnd_vld) begin
            err_nxt = 1'b1;
         end else begin
            pnd_vld_nxt  = 1'b1;
            pnd_id_nxt   = i_coh_rqst;
            pnd_trsc_nxt = i_coh_trsc;
            pnd_addr_nxt = i_coh_addr;
         end
      end
   end

   assign i_coh_resp  = (state == S_GRANT) ? cur_id : 8'd0;
   assign i_coh_mesi  = (state == S_GRANT) ? mesi : 8'd0;
   assign i_coh_plock = 1'b0;
   assign p_coh_rqst  = (state == S_SNOOP) ? {NPORT{cur_id}} : '0;
   assign p_coh_trsc  = (state != S_IDLE) ? cur_trsc : 8'd0;
   assign p_coh_addr  = (state != S_IDLE) ? cur_addr : 64'd0;
   assign p_coh_lock  = i_coh_lock;
   assign err         = err_q;

endmodule

// File: tb/tb_coh_snoop_hub.sv
// Self-checking bench for coh_snoop_hub (NPORT=2, TMO=15): cycle table plus directed multi-cycle sequences.
module tb_coh_snoop_hub;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_coh_lock = 1'b0;
   logic [7:0]  i_coh_rqst = 8'd0;
   logic [7:0]  i_coh_trsc = 8'd0;
   logic [63:0] i_coh_addr = 64'd0;
   logic [7:0]  i_coh_resp;
   logic [7:0]  i_coh_mesi;
   logic        i_coh_plock;
   logic [15:0] p_coh_rqst;
   logic [7:0]  p_coh_trsc;
   logic [63:0] p_coh_addr;
   logic        p_coh_lock;
   logic [15:0] p_coh_resp = 16'd0;
   logic [15:0] p_coh_mesi = 16'd0;
   logic        err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   coh_snoop_hub #(.NPORT(2), .TMO(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_coh_lock (i_coh_lock),
      .i_coh_rqst (i_coh_rqst),
      .i_coh_trsc (i_coh_trsc),
      .i_coh_addr (i_coh_addr),
      .i_coh_resp (i_coh_resp),
      .i_coh_mesi (i_coh_mesi),
      .i_coh_plock(i_coh_plock),
      .p_coh_rqst (p_coh_rqst),
      .p_coh_trsc (p_coh_trsc),
      .p_coh_addr (p_coh_addr),
      .p_coh_lock (p_coh_lock),
      .p_coh_resp (p_coh_resp),
      .p_coh_mesi (p_coh_mesi),
      .err        (err)
   );

   typedef struct {
      logic        rst;
      logic [7:0]  rqst;
      logic [7:0]  trsc;
      logic [63:0] addr;
      logic [7:0]  r0, m0, r1, m1;
      logic [7:0]  e_resp;
      logic [7:0]  e_mesi;
      logic [15:0] e_prqst;
      logic [7:0]  e_trsc;
      logic [63:0] e_paddr;
      logic        e_err;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(logic r, logic [7:0] rq, logic [7:0] tr, logic [63:0] a,
                               logic [7:0] r0, logic [7:0] m0, logic [7:0] r1, logic [7:0] m1,
                               logic [7:0] er, logic [7:0] em, logic [15:0] ep, logic [7:0] et,
                               logic [63:0] ea, logic ee);
      vec_t v;
      v.rst = r; v.rqst = rq; v.trsc = tr; v.addr = a;
      v.r0 = r0; v.m0 = m0; v.r1 = r1; v.m1 = m1;
      v.e_resp = er; v.e_mesi = em; v.e_prqst = ep; v.e_trsc = et; v.e_paddr = ea; v.e_err = ee;
      return v;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic req(input logic [7:0] id, input logic [7:0] tr, input logic [63:0] a);
      i_coh_rqst = id;
      i_coh_trsc = tr;
      i_coh_addr = a;
   endtask

   task automatic peer(input logic [7:0] r0, input logic [7:0] m0, input logic [7:0] r1, input logic [7:0] m1);
      p_coh_resp = {r1, r0};
      p_coh_mesi = {m1, m0};
   endtask

   initial begin
      int bad;

      // Single request with both peers at t+2, then a merge where peer0 answers in SNOOP (ignored) and later in WAIT.
      tbl[0]  = mk(1, 0,     0,     64'h0,         0, 0, 0, 0,             0,     0,     16'h0,    0,     64'h0,         0);
      tbl[1]  = mk(0, 8'h01, 8'h01, 64'h8000_0040, 0, 0, 0, 0,             0,     0,     16'h0,    0,     64'h0,         0);
      tbl[2]  = mk(0, 0,     0,     64'h0,         0, 0, 0, 0,             0,     0,     16'h0101, 8'h01, 64'h8000_0040, 0);
      tbl[3]  = mk(0, 0,     0,     64'h0,         8'h01, 8'h00, 8'h01, 8'h02, 0, 0,     16'h0,    8'h01, 64'h8000_0040, 0);
      tbl[4]  = mk(0, 0,     0,     64'h0,         0, 0, 0, 0,             8'h01, 8'h02, 16'h0,    8'h01, 64'h8000_0040, 0);
      tbl[5]  = mk(0, 0,     0,     64'h0,         0, 0, 0, 0,             0,     0,     16'h0,    0,     64'h0,         0);
      tbl[6]  = mk(0, 8'h22, 8'h03, 64'h1000,      0, 0, 0, 0,             0,     0,     16'h0,    0,     64'h0,         0);
      tbl[7]  = mk(0, 0,     0,     64'h0,         8'h22, 8'h40, 0, 0,     0,     0,     16'h2222, 8'h03, 64'h1000,      0);
      tbl[8]  = mk(0, 0,     0,     64'h0,         0, 0, 8'h22, 8'h08,     0,     0,     16'h0,    8'h03, 64'h1000,      0);
      tbl[9]  = mk(0, 0,     0,     64'h0,         8'h22, 8'h01, 0, 0,     0,     0,     16'h0,    8'h03, 64'h1000,      0);
      tbl[10] = mk(0, 0,     0,     64'h0,         0, 0, 0, 0,             8'h22, 8'h09, 16'h0,    8'h03, 64'h1000,      0);
      tbl[11] = mk(0, 0,     0,     64'h0,         0, 0, 0, 0,             0,     0,     16'h0,    0,     64'h0,         0);

      tick;
      tick;
      for (int i = 0; i < 12; i++) begin
         rst = tbl[i].rst;
         req(tbl[i].rqst, tbl[i].trsc, tbl[i].addr);
         peer(tbl[i].r0, tbl[i].m0, tbl[i].r1, tbl[i].m1);
         #1;
         check($sformatf("row%0d_resp", i),  i_coh_resp, tbl[i].e_resp);
         check($sformatf("row%0d_mesi", i),  i_coh_mesi, tbl[i].e_mesi);
         check($sformatf("row%0d_prqst", i), p_coh_rqst, tbl[i].e_prqst);
         check($sformatf("row%0d_ptrsc", i), p_coh_trsc, tbl[i].e_trsc);
         check($sformatf("row%0d_paddr", i), p_coh_addr, tbl[i].e_paddr);
         check($sformatf("row%0d_err", i),   err,        tbl[i].e_err);
         tick;
      end
      req(0, 0, 0);
      peer(0, 0, 0, 0);

      // Staggered peers: peer0 at t+2, peer1 at t+9, grant at t+10 only.
      req(8'h01, 8'h01, 64'h2000); tick;
      req(0, 0, 0); tick;
      peer(8'h01, 8'h04, 0, 0); tick;
      peer(0, 0, 0, 0);
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         if (i_coh_resp != 8'd0) bad++;
         tick;
      end
      if (i_coh_resp != 8'd0) bad++;
      check("stagger_no_early_grant", bad, 0);
      peer(0, 0, 8'h01, 8'h01); tick;
      peer(0, 0, 0, 0);
      check("stagger_resp", i_coh_resp, 8'h01);
      check("stagger_mesi", i_coh_mesi, 8'h05);
      tick;
      check("stagger_resp_one_cycle", i_coh_resp, 8'h00);

      // Wrong id from peer1 is ignored, including its MESI.
      req(8'h01, 8'h01, 64'h2400); tick;
      req(0, 0, 0); tick;
      peer(8'h01, 8'h00, 8'h05, 8'h80); tick;
      peer(0, 0, 0, 0);
      check("wrongid_no_grant", i_coh_resp, 8'h00);
      tick;
      peer(0, 0, 8'h01, 8'h02); tick;
      peer(0, 0, 0, 0);
      check("wrongid_resp", i_coh_resp, 8'h01);
      check("wrongid_mesi", i_coh_mesi, 8'h02);
      tick;

      // Pending: second request during WAIT is served after one idle cycle.
      req(8'h01, 8'h01, 64'h3000); tick;
      req(0, 0, 0); tick;
      req(8'h01, 8'h01, 64'h3040); tick;
      req(0, 0, 0);
      peer(8'h01, 8'h00, 8'h01, 8'h10); tick;
      peer(0, 0, 0, 0);
      check("pend_grant1_resp", i_coh_resp, 8'h01);
      check("pend_grant1_mesi", i_coh_mesi, 8'h10);
      check("pend_grant1_addr", p_coh_addr, 64'h3000);
      tick;
      check("pend_idle_resp", i_coh_resp, 8'h00);
      check("pend_idle_addr", p_coh_addr, 64'h0);
      tick;
      check("pend_snoop2_rqst", p_coh_rqst, 16'h0101);
      check("pend_snoop2_addr", p_coh_addr, 64'h3040);
      tick;
      peer(8'h01, 8'h01, 8'h01, 8'h00); tick;
      peer(0, 0, 0, 0);
      check("pend_grant2_resp", i_coh_resp, 8'h01);
      check("pend_grant2_mesi", i_coh_mesi, 8'h01);
      check("pend_grant2_addr", p_coh_addr, 64'h3040);
      check("pend_no_err", err, 1'b0);
      tick;
      check("pend_after_resp", i_coh_resp, 8'h00);

      // Lock passthrough and reserved peer-lock output.
      i_coh_lock = 1'b1; #1;
      check("lock_pass_hi", p_coh_lock, 1'b1);
      check("plock_tied", i_coh_plock, 1'b0);
      i_coh_lock = 1'b0; #1;
      check("lock_pass_lo", p_coh_lock, 1'b0);
      tick;

      // Timeout: peer1 silent; 15 WAIT cycles then grant with err.
      req(8'h05, 8'h02, 64'h4000); tick;
      req(0, 0, 0); tick;
      peer(8'h05, 8'h04, 0, 0);
      bad = 0;
      for (int c = 0; c < 15; c++) begin
         if (c == 1) peer(0, 0, 0, 0);
         if (i_coh_resp != 8'd0 || err != 1'b0) bad++;
         tick;
      end
      check("tmo_no_early_grant", bad, 0);
      check("tmo_resp", i_coh_resp, 8'h05);
      check("tmo_mesi", i_coh_mesi, 8'h04);
      check("tmo_err", err, 1'b1);
      tick; tick; tick;
      check("tmo_err_sticky", err, 1'b1);
      check("tmo_idle_resp", i_coh_resp, 8'h00);

      // Reset during WAIT: no grant, outputs cleared, err cleared, fresh request completes.
      req(8'h07, 8'h02, 64'h5000); tick;
      req(0, 0, 0); tick;
      rst = 1'b1; tick;
      rst = 1'b0;
      check("rst_resp", i_coh_resp, 8'h00);
      check("rst_prqst", p_coh_rqst, 16'h0);
      check("rst_paddr", p_coh_addr, 64'h0);
      check("rst_ptrsc", p_coh_trsc, 8'h00);
      check("rst_err", err, 1'b0);
      peer(8'h07, 8'h01, 8'h07, 8'h01); tick;
      peer(0, 0, 0, 0);
      check("rst_no_grant", i_coh_resp, 8'h00);
      req(8'h09, 8'h01, 64'h6000); tick;
      req(0, 0, 0); tick;
      peer(8'h09, 8'h02, 8'h09, 8'h00); tick;
      peer(0, 0, 0, 0);
      check("rst_fresh_resp", i_coh_resp, 8'h09);
      check("rst_fresh_mesi", i_coh_mesi, 8'h02);
      tick;

      // Overflow: third request while the slot is full is dropped and sets err.
      req(8'h02, 8'h01, 64'h7000); tick;
      req(8'h03, 8'h01, 64'h7040); tick;
      req(8'h04, 8'h01, 64'h7080); tick;
      req(0, 0, 0);
      check("drop_err", err, 1'b1);
      peer(8'h02, 0, 8'h02, 0); tick;
      peer(0, 0, 0, 0);
      check("drop_grant_a", i_coh_resp, 8'h02);
      tick; tick;
      check("drop_snoop_b", p_coh_rqst, 16'h0303);
      check("drop_addr_b", p_coh_addr, 64'h7040);
      tick;
      peer(8'h03, 0, 8'h03, 0); tick;
      peer(0, 0, 0, 0);
      check("drop_grant_b", i_coh_resp, 8'h03);
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         tick;
         if (p_coh_rqst != 16'h0 || i_coh_resp != 8'h00) bad++;
      end
      check("drop_no_third", bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/coh_snoop_hub.md
Name: coh_snoop_hub

Overview:
- Responder end of the coherence request interface used by DMA initiators such as the SD card controller wrapper.
- Accepts one-cycle ownership requests (id, transaction type, address) from a single initiator port.
- Broadcasts each request as a snoop to NPORT cached peer ports and collects every peer response.
- Returns a one-cycle grant carrying the request id and merged MESI state. Sits in the SoC interconnect between the DMA coherence master and the core/L2 snoop slaves.

Parameters:
- NPORT, 2, number of snooped peer ports (1..8)
- TMO, 1023, timeout in cycles waiting for peer responses; 0 disables timeout

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_coh_lock  in  1  initiator holds its lock (burst in progress)
- i_coh_rqst  in  8  request id; nonzero for one cycle = new request
- i_coh_trsc  in  8  transaction type, sampled with i_coh_rqst
- i_coh_addr  in  64  block address, sampled with i_coh_rqst
- i_coh_resp  out  8  grant: equals latched id for exactly one cycle
- i_coh_mesi  out  8  merged peer MESI, valid with i_coh_resp
- i_coh_plock  out  1  OR of peer locks, for the initiator's lock qualification
- p_coh_rqst  out  8*NPORT  per-peer snoop id, one-cycle pulse
- p_coh_trsc  out  8  broadcast transaction type
- p_coh_addr  out  64  broadcast address
- p_coh_lock  out  1  copy of i_coh_lock to peers
- p_coh_resp  in  8*NPORT  per-peer response; id value = done
- p_coh_mesi  in  8*NPORT  per-peer MESI, valid with p_coh_resp
- err  out  1  sticky: timeout occurred; cleared by reset only

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Pending slot empty; done mask 0; timeout counter 0.
- Request capture:
  - Any cycle with i_coh_rqst != 0 latches {id, trsc, addr}.
  - If the FSM is IDLE, the request goes straight to SNOOP on the next cycle.
  - Otherwise it goes into a single-entry pending slot.
  - A request arriving while the pending slot is full is dropped and err is set.
- FSM states:
  - IDLE: if the pending slot is full, load it (slot cleared) and go to SNOOP; else wait for a new request.
  - SNOOP (1 cycle): drive p_coh_rqst[k] = id for every k; p_coh_trsc/p_coh_addr hold the latched values until the FSM returns to IDLE. Clear the done mask and counter; go to WAIT.
  - WAIT:
    - Per peer, p_coh_resp[k] == id sets done[k] and ORs p_coh_mesi[k] into the merged MESI.
    - Responses with any other value are ignored.
    - When done is all ones (including same-cycle responses), go to GRANT.
    - Counter increments each WAIT cycle. With TMO != 0 and counter == TMO, set err and go to GRANT with the MESI merged so far.
  - GRANT (1 cycle): i_coh_resp = id, i_coh_mesi = merged; next state IDLE.
- Latency: request in cycle t gives snoop pulse at t+1. If all peers answer at t+2, the grant is at t+3. Minimum grant latency is 3 cycles.
- Back-to-back: a request arriving during GRANT goes to pending. IDLE then dispatches it, adding one idle cycle between grants.
- p_coh_lock = i_coh_lock combinationally. i_coh_plock = OR of peer locks is not available, so it is tied to 0 in this revision; the port is reserved.
- Peers that respond during SNOOP (same cycle as the pulse) are ignored; responses are counted only in WAIT.
- Reset mid-operation returns to IDLE within one cycle with no grant issued; the pending slot is discarded.
- MESI merge is a bitwise OR over 8 bits. Nonresponding peers contribute 0.

Test Plan:
- Single request: id=1, trsc=1, addr=0x8000_0040; both peers respond id 1 at t+2 with mesi 0 and 0x02 -> i_coh_resp=1 at t+3 for one cycle, i_coh_mesi=0x02, p_coh_addr=0x8000_0040 throughout.
- Staggered peers: peer0 responds at +2, peer1 at +9 -> grant exactly one cycle after peer1's response; no early grant.
- Wrong id: peer1 responds 0x05 to id 1, then 0x01 later -> 0x05 is ignored; grant follows the 0x01.
- Pending: second request id=1, addr +0x40, arrives during WAIT -> first grant, one IDLE cycle, then snoop of the second address; two grants total, in order.
- Timeout: TMO=15, peer1 never responds -> grant at WAIT cycle 15, err=1 and stays 1 until rst.
- Reset mid-WAIT: rst pulsed during WAIT -> no i_coh_resp, all outputs 0 next cycle; a fresh request afterward completes normally.
